// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and helpers for the core's memory-side blocks.
//   mem_arb_state_t : arbiter FSM state (IDLE / ISSUE / WAIT)
//   mem_grant_t     : which requester owns the memory port (GNT_IF / GNT_DM)
//   starve_inc      : saturating increment used by the fetch-starvation counter
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } mem_grant_t;

  localparam int unsigned STARVE_W = 3;

  // Fetches always read a full word.
  localparam logic [3:0] FETCH_BE = 4'b1111;

  // Saturating increment: never counts past the limit.
  function automatic logic [STARVE_W-1:0] starve_inc(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] limit
  );
    logic [STARVE_W-1:0] res;
    if (cnt >= limit) begin
      res = limit;
    end else begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_chk.sv
// -----------------------------------------------------------------------------
// mem_arbiter_chk
// Protocol checker for mem_arbiter: the memory may only return a response while
// the arbiter is waiting for one.
//   clk, rst        : clock / synchronous active-high reset
//   i_state         : arbiter FSM state
//   i_mem_rsp_valid : memory response strobe
// -----------------------------------------------------------------------------
module mem_arbiter_chk
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst,
  input mem_arb_state_t i_state,
  input logic           i_mem_rsp_valid
);

  // Flag a memory response that arrives in IDLE or ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rsp_only_in_wait: assert (!(i_mem_rsp_valid && (i_state != WAIT)));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter (instruction fetch, data memory) in front of a single memory
// port with at most one outstanding transaction. The data port has priority; a
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive data
// grants made while a fetch was waiting. A fetch flush drops the in-flight
// fetch response without disturbing the memory-side handshake.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   if_req_* / if_rsp_*   : fetch request (valid/addr/ready) and response
//   if_flush              : redirect; kills any in-flight fetch response
//   dm_req_* / dm_rsp_*   : data request (valid/we/addr/wdata/be/ready), response
//   mem_req_* / mem_rsp_* : memory request channel and in-order response
// -----------------------------------------------------------------------------
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  input  logic        if_flush,
  input  logic        dm_req_valid,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_addr,
  input  logic [31:0] dm_req_wdata,
  input  logic [3:0]  dm_req_be,
  output logic        dm_req_ready,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_rdata,
  output logic        mem_req_valid,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  mem_arb_state_t      r_state;
  mem_grant_t          r_grant;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_drop;
  logic                r_dm_we;    // outstanding data transaction is a write

  mem_arb_state_t      w_state_nxt;
  mem_grant_t          w_grant_nxt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_drop_nxt;
  logic                w_dm_we_nxt;
  logic                w_pick_if;
  logic                w_if_flush_hit;

  // Fetch wins only when the data port is idle or the fetch has starved.
  assign w_pick_if = if_req_valid && (!dm_req_valid || (r_starve_cnt == LIMIT));

  // A flush only matters while a fetch owns the memory port.
  assign w_if_flush_hit = if_flush && (r_grant == GNT_IF);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= GNT_DM;
      r_starve_cnt <= 3'd0;
      r_drop       <= 1'b0;
      r_dm_we      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_drop       <= w_drop_nxt;
      r_dm_we      <= w_dm_we_nxt;
    end
  end

  // Next-state logic: arbitration, handshake progress, drop tracking.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_starve_nxt = r_starve_cnt;
    w_drop_nxt   = r_drop;
    w_dm_we_nxt  = r_dm_we;
    case (r_state)
      IDLE: begin
        w_drop_nxt = 1'b0;
        if (if_req_valid || dm_req_valid) begin
          w_state_nxt = ISSUE;
          if (w_pick_if) begin
            w_grant_nxt  = GNT_IF;
            w_starve_nxt = 3'd0;
          end else begin
            w_grant_nxt = GNT_DM;
            // Only a data grant that makes a fetch wait counts as starvation.
            if (if_req_valid) begin
              w_starve_nxt = starve_inc(r_starve_cnt, LIMIT);
            end else begin
              w_starve_nxt = r_starve_cnt;
            end
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (w_if_flush_hit) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_drop_nxt = r_drop;
        end
        if (mem_req_ready) begin
          w_state_nxt = WAIT;
          w_dm_we_nxt = (r_grant == GNT_DM) ? dm_req_we : 1'b0;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          // Back to IDLE without granting; arbitration resumes next cycle.
          w_state_nxt = IDLE;
          w_drop_nxt  = 1'b0;
        end else if (w_if_flush_hit) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_drop_nxt = r_drop;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: request mux in ISSUE, zero-latency response routing in WAIT.
  always_comb begin
    if_req_ready  = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_rdata  = 32'd0;
    dm_req_ready  = 1'b0;
    dm_rsp_valid  = 1'b0;
    dm_rsp_rdata  = 32'd0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_wdata = 32'd0;
    mem_req_be    = 4'd0;
    // Outputs are forced quiet for the whole time reset is held.
    if (!rst) begin
      case (r_state)
        ISSUE: begin
          mem_req_valid = 1'b1;
          if (r_grant == GNT_IF) begin
            mem_req_addr = if_req_addr;
            mem_req_be   = FETCH_BE;
            if_req_ready = mem_req_ready;
          end else begin
            mem_req_we    = dm_req_we;
            mem_req_addr  = dm_req_addr;
            mem_req_wdata = dm_req_wdata;
            mem_req_be    = dm_req_be;
            dm_req_ready  = mem_req_ready;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (r_grant == GNT_IF) begin
              // A flush this cycle suppresses the response just like a
              // flush seen earlier in the transaction.
              if (!r_drop && !if_flush) begin
                if_rsp_valid = 1'b1;
                if_rsp_rdata = mem_rsp_rdata;
              end else begin
                if_rsp_valid = 1'b0;
              end
            end else begin
              dm_rsp_valid = 1'b1;
              dm_rsp_rdata = r_dm_we ? 32'd0 : mem_rsp_rdata;
            end
          end else begin
            if_rsp_valid = 1'b0;
          end
        end
        default: begin
          mem_req_valid = 1'b0;
        end
      endcase
    end else begin
      mem_req_valid = 1'b0;
    end
  end

  mem_arbiter_chk u_chk (
    .clk             (clk),
    .rst             (rst),
    .i_state         (r_state),
    .i_mem_rsp_valid (mem_rsp_valid)
  );

endmodule
